// File: rtl/mac_pattern_detect_if.sv
// Operand/result bundle for mac_pattern_detect; the master drives samples and the slave returns P and flags.
interface mac_pattern_detect_if #(
    parameter int unsigned A_WIDTH   = 10,
    parameter int unsigned B_WIDTH   = 10,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 in_valid;
    logic [A_WIDTH-1:0]   A;
    logic [B_WIDTH-1:0]   B;
    logic                 acc_en;
    logic                 cnt_clr;
    logic [ACC_WIDTH-1:0] P;
    logic                 out_valid;
    logic                 pattern_detect;
    logic                 pattern_b_detect;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] match_count;

    modport master (
        output in_valid, A, B, acc_en, cnt_clr,
        input  P, out_valid, pattern_detect, pattern_b_detect, overflow, match_count
    );

    modport slave (
        input  in_valid, A, B, acc_en, cnt_clr,
        output P, out_valid, pattern_detect, pattern_b_detect, overflow, match_count
    );
endinterface

// File: rtl/mac_pattern_detect.sv
// Three-stage multiply-accumulate with masked pattern / complement detection,
// sticky overflow (wrap or saturate) and a saturating match counter.
module mac_pattern_detect #(
    parameter int unsigned                A_WIDTH   = 10,
    parameter int unsigned                B_WIDTH   = 10,
    parameter int unsigned                ACC_WIDTH = 24,
    parameter logic [ACC_WIDTH-1:0]       PATTERN   = ACC_WIDTH'(36),
    parameter logic [ACC_WIDTH-1:0]       MASK      = '0,
    parameter bit                         SATURATE  = 1'b0,
    parameter int unsigned                CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    mac_pattern_detect_if.slave bus
);
    localparam int unsigned PW = A_WIDTH + B_WIDTH;

    logic                 r_v1, r_acc1;
    logic [A_WIDTH-1:0]   r_a1;
    logic [B_WIDTH-1:0]   r_b1;
    logic                 r_v2, r_acc2;
    logic [ACC_WIDTH-1:0] r_prod2;
    logic [ACC_WIDTH-1:0] r_p;
    logic                 r_ovalid, r_pd, r_pbd, r_ov;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [PW-1:0]        w_prod;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_pnext;
    logic                 w_carry, w_ov_next, w_pd, w_pbd;

    assign w_prod = PW'(r_a1) * PW'(r_b1);

    always_comb begin
        w_sum     = {1'b0, (r_acc2 ? r_p : {ACC_WIDTH{1'b0}})} + {1'b0, r_prod2};
        w_carry   = w_sum[ACC_WIDTH];
        w_pnext   = (w_carry && SATURATE) ? '1 : w_sum[ACC_WIDTH-1:0];
        // Overflow is sticky across accumulates; only a clean load clears it.
        w_ov_next = w_carry ? 1'b1 : (r_acc2 ? r_ov : 1'b0);
        w_pd      = ((w_pnext & ~MASK) == (PATTERN & ~MASK));
        w_pbd     = ((w_pnext & ~MASK) == (~PATTERN & ~MASK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_acc1 <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_a1   <= bus.A;
                r_b1   <= bus.B;
                r_acc1 <= bus.acc_en;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_acc2  <= 1'b0;
            r_prod2 <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_acc2  <= r_acc1;
                r_prod2 <= ACC_WIDTH'(w_prod);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p      <= '0;
            r_ov     <= 1'b0;
            r_ovalid <= 1'b0;
            r_pd     <= 1'b0;
            r_pbd    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_ovalid <= r_v2;
            r_pd     <= r_v2 & w_pd;
            r_pbd    <= r_v2 & w_pbd;
            if (r_v2) begin
                r_p  <= w_pnext;
                r_ov <= w_ov_next;
            end
            // Clear takes priority over a same-cycle match increment.
            if (bus.cnt_clr) begin
                r_cnt <= '0;
            end else if (r_v2 && w_pd && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.P                = r_p;
    assign bus.out_valid        = r_ovalid;
    assign bus.pattern_detect   = r_pd;
    assign bus.pattern_b_detect = r_pbd;
    assign bus.overflow         = r_ov;
    assign bus.match_count      = r_cnt;
endmodule

// File: tb/tb_mac_pattern_detect.sv
// Scoreboard bench for mac_pattern_detect across several parameter sets.
module tb_mac_pattern_detect;
    logic clk;
    logic rst;

    typedef struct {
        logic [23:0] p;
        logic        pd;
        logic        pbd;
        logic        ov;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[5][$];
    int checks = 0;
    int errors = 0;

    // {in_valid, A, B, acc_en, cnt_clr} per DUT
    logic [22:0] drv [5];

    mac_pattern_detect_if #(.ACC_WIDTH(24)) bus0 ();
    mac_pattern_detect_if #(.ACC_WIDTH(20)) bus1 ();
    mac_pattern_detect_if #(.ACC_WIDTH(20)) bus2 ();
    mac_pattern_detect_if #(.ACC_WIDTH(24)) bus3 ();
    mac_pattern_detect_if #(.ACC_WIDTH(24)) bus4 ();

    assign {bus0.in_valid, bus0.A, bus0.B, bus0.acc_en, bus0.cnt_clr} = drv[0];
    assign {bus1.in_valid, bus1.A, bus1.B, bus1.acc_en, bus1.cnt_clr} = drv[1];
    assign {bus2.in_valid, bus2.A, bus2.B, bus2.acc_en, bus2.cnt_clr} = drv[2];
    assign {bus3.in_valid, bus3.A, bus3.B, bus3.acc_en, bus3.cnt_clr} = drv[3];
    assign {bus4.in_valid, bus4.A, bus4.B, bus4.acc_en, bus4.cnt_clr} = drv[4];

    mac_pattern_detect #(.ACC_WIDTH(24)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mac_pattern_detect #(.ACC_WIDTH(20), .SATURATE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mac_pattern_detect #(.ACC_WIDTH(20), .SATURATE(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mac_pattern_detect #(.ACC_WIDTH(24), .MASK(24'h00000F), .PATTERN(24'd36)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    mac_pattern_detect #(.ACC_WIDTH(24), .MASK(24'h000000), .PATTERN(24'hFFFFDB)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int d, input logic ov_valid, input logic [23:0] p, input logic pd,
                       input logic pbd, input logic ov, input logic [7:0] cnt);
        exp_t e;
        if (ov_valid) begin
            if (q[d].size() == 0) begin
                chk($sformatf("dut%0d_unexpected_out_valid", d), 32'd1, 32'd0);
            end else begin
                e = q[d].pop_front();
                chk($sformatf("dut%0d_P", d), 32'(p), 32'(e.p));
                chk($sformatf("dut%0d_pattern_detect", d), 32'(pd), 32'(e.pd));
                chk($sformatf("dut%0d_pattern_b_detect", d), 32'(pbd), 32'(e.pbd));
                chk($sformatf("dut%0d_overflow", d), 32'(ov), 32'(e.ov));
                chk($sformatf("dut%0d_match_count", d), 32'(cnt), 32'(e.cnt));
            end
        end else begin
            chk($sformatf("dut%0d_detect_idle", d), {30'd0, pd, pbd}, 32'd0);
        end
    endtask

    always @(negedge clk) mon(0, bus0.out_valid, 24'(bus0.P), bus0.pattern_detect, bus0.pattern_b_detect, bus0.overflow, bus0.match_count);
    always @(negedge clk) mon(1, bus1.out_valid, 24'(bus1.P), bus1.pattern_detect, bus1.pattern_b_detect, bus1.overflow, bus1.match_count);
    always @(negedge clk) mon(2, bus2.out_valid, 24'(bus2.P), bus2.pattern_detect, bus2.pattern_b_detect, bus2.overflow, bus2.match_count);
    always @(negedge clk) mon(3, bus3.out_valid, 24'(bus3.P), bus3.pattern_detect, bus3.pattern_b_detect, bus3.overflow, bus3.match_count);
    always @(negedge clk) mon(4, bus4.out_valid, 24'(bus4.P), bus4.pattern_detect, bus4.pattern_b_detect, bus4.overflow, bus4.match_count);

    task automatic expect_out(input int d, input logic [23:0] p, input logic pd, input logic pbd,
                              input logic ov, input logic [7:0] cnt);
        exp_t e;
        e.p = p; e.pd = pd; e.pbd = pbd; e.ov = ov; e.cnt = cnt;
        q[d].push_back(e);
    endtask

    task automatic step(input int d, input logic v, input logic [9:0] a, input logic [9:0] b,
                        input logic acc, input logic clr);
        for (int i = 0; i < 5; i++) drv[i] = '0;
        drv[d] = {v, a, b, acc, clr};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size() == 0) break;
            idle(1);
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) drv[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_P", 32'(bus0.P), 32'd0);
        chk("reset_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("reset_overflow", 32'(bus0.overflow), 32'd0);
        chk("reset_match_count", 32'(bus0.match_count), 32'd0);
        rst = 1'b0;
        idle(1);

        // 6x6 load hits PATTERN=36, then P holds with detect low
        expect_out(0, 24'd36, 1'b1, 1'b0, 1'b0, 8'd1);
        step(0, 1'b1, 10'd6, 10'd6, 1'b0, 1'b0);
        idle(2);
        chk("t1_out_valid", 32'(bus0.out_valid), 32'd1);
        idle(1);
        chk("t1_hold_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("t1_hold_P", 32'(bus0.P), 32'd36);
        chk("t1_hold_detect", 32'(bus0.pattern_detect), 32'd0);

        // back-to-back load then accumulate
        expect_out(0, 24'd12, 1'b0, 1'b0, 1'b0, 8'd1);
        expect_out(0, 24'd36, 1'b1, 1'b0, 1'b0, 8'd2);
        step(0, 1'b1, 10'd3, 10'd4, 1'b0, 1'b0);
        step(0, 1'b1, 10'd4, 10'd6, 1'b1, 1'b0);
        drain();

        // 20-bit saturate: overflow, stays saturated, clean load clears
        expect_out(1, 24'd1046529, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_out(1, 24'd1048575, 1'b0, 1'b0, 1'b1, 8'd0);
        expect_out(1, 24'd1048575, 1'b0, 1'b0, 1'b1, 8'd0);
        expect_out(1, 24'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1, 1'b1, 10'd1023, 10'd1023, 1'b0, 1'b0);
        step(1, 1'b1, 10'd1023, 10'd1023, 1'b1, 1'b0);
        step(1, 1'b1, 10'd1023, 10'd1023, 1'b1, 1'b0);
        step(1, 1'b1, 10'd1, 10'd1, 1'b0, 1'b0);
        drain();

        // 20-bit wrap: overflow sticky through a non-overflowing accumulate
        expect_out(2, 24'd1046529, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_out(2, 24'd1044482, 1'b0, 1'b0, 1'b1, 8'd0);
        expect_out(2, 24'd1044483, 1'b0, 1'b0, 1'b1, 8'd0);
        expect_out(2, 24'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(2, 1'b1, 10'd1023, 10'd1023, 1'b0, 1'b0);
        step(2, 1'b1, 10'd1023, 10'd1023, 1'b1, 1'b0);
        step(2, 1'b1, 10'd1, 10'd1, 1'b1, 1'b0);
        step(2, 1'b1, 10'd1, 10'd1, 1'b0, 1'b0);
        drain();

        // masked compare: low nibble ignored
        expect_out(3, 24'h00002F, 1'b1, 1'b0, 1'b0, 8'd1);
        expect_out(3, 24'h000030, 1'b0, 1'b0, 1'b0, 8'd1);
        step(3, 1'b1, 10'd47, 10'd1, 1'b0, 1'b0);
        step(3, 1'b1, 10'd48, 10'd1, 1'b0, 1'b0);
        drain();

        // complement pattern match
        expect_out(4, 24'd36, 1'b0, 1'b1, 1'b0, 8'd0);
        step(4, 1'b1, 10'd6, 10'd6, 1'b0, 1'b0);
        drain();

        // alternating valids with cnt_clr between matches
        step(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
        chk("t5_clear0", 32'(bus0.match_count), 32'd0);
        expect_out(0, 24'd36, 1'b1, 1'b0, 1'b0, 8'd1);
        expect_out(0, 24'd36, 1'b1, 1'b0, 1'b0, 8'd1);
        step(0, 1'b1, 10'd6, 10'd6, 1'b0, 1'b0);
        step(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
        step(0, 1'b1, 10'd6, 10'd6, 1'b0, 1'b0);
        step(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
        chk("t5_clear_mid", 32'(bus0.match_count), 32'd0);
        drain();

        // clear coincident with a match increment
        expect_out(0, 24'd36, 1'b1, 1'b0, 1'b0, 8'd0);
        step(0, 1'b1, 10'd6, 10'd6, 1'b0, 1'b0);
        step(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
        step(0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
        drain();

        // reset with two samples in flight: nothing emerges afterwards
        step(0, 1'b1, 10'd5, 10'd5, 1'b0, 1'b0);
        step(0, 1'b1, 10'd6, 10'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drv[i] = '0;
        rst = 1'b1;
        #1;
        chk("t6_P", 32'(bus0.P), 32'd0);
        chk("t6_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("t6_match_count", 32'(bus0.match_count), 32'd0);
        chk("t6_overflow", 32'(bus2.overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        chk("t6_P_after", 32'(bus0.P), 32'd0);

        for (int i = 0; i < 5; i++) chk($sformatf("dut%0d_queue_empty", i), 32'(q[i].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
